// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the simplified USB full-speed receiver.
// Optional bit unstuffing is enabled with the macro USB_RX_BIT_UNSTUFF_EN.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_PID   = 3'd2,
    ST_CRC5  = 3'd3,
    ST_CRC16 = 3'd4,
    ST_DATA  = 3'd5,
    ST_EOP   = 3'd6,
    ST_ERR   = 3'd7
  } rx_state_e;

  localparam logic [7:0] PID_IN       = 8'h69;
  localparam logic [7:0] PID_DATA0    = 8'hC3;
  localparam logic [7:0] PID_ACK      = 8'hD2;
  localparam logic [7:0] SYNC_PATTERN = 8'h80;

  localparam logic [1:0] PID_TYPE_TOKEN = 2'b01;
  localparam logic [1:0] PID_TYPE_HAND  = 2'b10;
  localparam logic [1:0] PID_TYPE_DATA  = 2'b11;

  localparam int unsigned LEN_SYNC  = 8;
  localparam int unsigned LEN_PID   = 8;
  localparam int unsigned LEN_CRC5  = 5;
  localparam int unsigned LEN_CRC16 = 16;
  localparam int unsigned LEN_DATA  = 64;

  // Upper nibble of a PID must be the complement of the lower nibble.
  function automatic logic pid_ok(input logic [7:0] pid);
    return (pid[7:4] == ~pid[3:0]);
  endfunction

  // Index of the final bit of the field collected in a given state.
  function automatic logic [6:0] field_last(input rx_state_e st);
    case (st)
      ST_SYNC:  return 7'(LEN_SYNC - 1);
      ST_PID:   return 7'(LEN_PID - 1);
      ST_CRC5:  return 7'(LEN_CRC5 - 1);
      ST_CRC16: return 7'(LEN_CRC16 - 1);
      ST_DATA:  return 7'(LEN_DATA - 1);
      default:  return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_line_decoder.sv
// Line front end: synchronizer, J/K edge detect, drift-tracking bit timer,
// sample strobe, SE0 detect and NRZI decode. Bit unstuffing is active when
// USB_RX_BIT_UNSTUFF_EN is defined.
module usb_rx_line_decoder
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_plus,
  input  logic d_minus,
  input  logic idle_i,
  input  logic count_en_i,
  output logic start_o,
  output logic bit_valid_o,
  output logic bit_o,
  output logic se0_o,
  output logic j_o,
  output logic stuff_err_o
);

  localparam int unsigned TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef USB_RX_BIT_UNSTUFF_EN
  localparam logic UNSTUFF = 1'b1;
`else
  localparam logic UNSTUFF = 1'b0;
`endif

  logic [1:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic          lvl_q, lvl_d;          // last J/K level seen, 1 = J
  logic          nrzi_prev_q, nrzi_prev_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    ones_q, ones_d;

  logic is_j, is_k, is_se0, edge_s, strobe, decoded, stuff_slot;

  // Synchronizer, edge tracking, bit timer, NRZI history and ones counter.
  always_comb begin
    sync1_d = {d_plus, d_minus};
    sync2_d = sync1_q;
    is_se0  = (sync2_q == 2'b00);
    is_k    = (sync2_q == 2'b01);
    is_j    = sync2_q[1];           // (1,1) is treated as J
    edge_s  = (is_j || is_k) && (is_j != lvl_q);
    lvl_d   = (is_j || is_k) ? is_j : lvl_q;

    if (edge_s || (timer_q == TW'(CLKS_PER_BIT - 1))) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    strobe     = !idle_i && (timer_q == TW'(SAMPLE_POINT));
    decoded    = (is_j == nrzi_prev_q);
    stuff_slot = UNSTUFF && count_en_i && (ones_q == 3'd6);

    if (idle_i) begin
      nrzi_prev_d = 1'b1;
    end else if (strobe && !is_se0) begin
      nrzi_prev_d = is_j;
    end else begin
      nrzi_prev_d = nrzi_prev_q;
    end

    if (idle_i || !count_en_i) begin
      ones_d = 3'd0;
    end else if (strobe && !is_se0) begin
      if (stuff_slot || !decoded) begin
        ones_d = 3'd0;
      end else begin
        ones_d = ones_q + 3'd1;
      end
    end else begin
      ones_d = ones_q;
    end

    start_o     = edge_s && is_k;
    bit_valid_o = strobe && !is_se0 && !stuff_slot;
    bit_o       = decoded;
    se0_o       = strobe && is_se0;
    j_o         = strobe && is_j;
    stuff_err_o = strobe && !is_se0 && stuff_slot && decoded;
  end

  // Front-end state registers; idle line is J.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sync1_q     <= 2'b10;
      sync2_q     <= 2'b10;
      lvl_q       <= 1'b1;
      nrzi_prev_q <= 1'b1;
      timer_q     <= '0;
      ones_q      <= 3'd0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      lvl_q       <= lvl_d;
      nrzi_prev_q <= nrzi_prev_d;
      timer_q     <= timer_d;
      ones_q      <= ones_d;
    end
  end

endmodule

// File: rtl/usb_receiver.sv
// Simplified USB full-speed packet receiver: frames SYNC/PID/CRC/DATA/EOP and
// latches each field onto a held output register. Bit unstuffing is enabled
// with USB_RX_BIT_UNSTUFF_EN.
module usb_receiver
  import usb_rx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned SAMPLE_POINT = 3
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        d_plus,
  input  logic        d_minus,
  output logic [7:0]  rcv_sync,
  output logic [7:0]  rcv_pid,
  output logic [4:0]  rcv_crc5,
  output logic [15:0] rcv_crc16,
  output logic [63:0] rcv_data
);

  rx_state_e   state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic [62:0] sr_q, sr_d;
  logic        se0_seen_q, se0_seen_d;
  logic [7:0]  rcv_sync_q, rcv_sync_d, rcv_pid_q, rcv_pid_d;
  logic [4:0]  rcv_crc5_q, rcv_crc5_d;
  logic [15:0] rcv_crc16_q, rcv_crc16_d;
  logic [63:0] rcv_data_q, rcv_data_d;

  logic        start_s, bit_valid_s, bit_s, se0_s, j_s, stuff_err_s;
  logic        in_field_s, counting_s, last_bit_s;
  logic [63:0] sr_next_s;

  assign in_field_s = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                      (state_q == ST_CRC5) || (state_q == ST_CRC16) ||
                      (state_q == ST_DATA);
  assign counting_s = in_field_s && (state_q != ST_SYNC);
  assign sr_next_s  = {bit_s, sr_q};
  assign last_bit_s = in_field_s && bit_valid_s && (cnt_q == field_last(state_q));

  usb_rx_line_decoder #(
    .CLKS_PER_BIT(CLKS_PER_BIT),
    .SAMPLE_POINT(SAMPLE_POINT)
  ) u_line (
    .clk        (clk),
    .n_rst      (n_rst),
    .d_plus     (d_plus),
    .d_minus    (d_minus),
    .idle_i     (state_q == ST_IDLE),
    .count_en_i (counting_s),
    .start_o    (start_s),
    .bit_valid_o(bit_valid_s),
    .bit_o      (bit_s),
    .se0_o      (se0_s),
    .j_o        (j_s),
    .stuff_err_o(stuff_err_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: field sequencing, SE0 abort and EOP/ERR recovery.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_s) state_d = ST_SYNC;
        else         state_d = ST_IDLE;
      end
      ST_SYNC, ST_PID, ST_CRC5, ST_CRC16, ST_DATA: begin
        if (se0_s) begin
          state_d = ST_EOP;
        end else if (stuff_err_s) begin
          state_d = ST_ERR;
        end else if (last_bit_s) begin
          case (state_q)
            ST_SYNC: state_d = (sr_next_s[63:56] == SYNC_PATTERN) ? ST_PID : ST_ERR;
            ST_PID: begin
              if (!pid_ok(sr_next_s[63:56])) begin
                state_d = ST_ERR;
              end else begin
                case (sr_next_s[57:56])
                  PID_TYPE_TOKEN: state_d = ST_CRC5;
                  PID_TYPE_DATA:  state_d = ST_CRC16;
                  PID_TYPE_HAND:  state_d = ST_EOP;
                  default:        state_d = ST_ERR;
                endcase
              end
            end
            ST_CRC5:  state_d = ST_EOP;
            ST_CRC16: state_d = ST_DATA;
            ST_DATA:  state_d = ST_EOP;
            default:  state_d = ST_ERR;
          endcase
        end else begin
          state_d = state_q;
        end
      end
      ST_EOP, ST_ERR: begin
        if (j_s && se0_seen_q) state_d = ST_IDLE;
        else                   state_d = state_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/datapath logic: shift register, bit counter and field commits.
  always_comb begin
    rcv_sync_d  = rcv_sync_q;
    rcv_pid_d   = rcv_pid_q;
    rcv_crc5_d  = rcv_crc5_q;
    rcv_crc16_d = rcv_crc16_q;
    rcv_data_d  = rcv_data_q;
    sr_d        = bit_valid_s ? sr_next_s[63:1] : sr_q;

    if (state_d != state_q) begin
      cnt_d = 7'd0;
    end else if (in_field_s && bit_valid_s) begin
      cnt_d = cnt_q + 7'd1;
    end else begin
      cnt_d = cnt_q;
    end

    if ((state_q == ST_EOP) || (state_q == ST_ERR)) begin
      se0_seen_d = se0_seen_q || se0_s;
    end else begin
      se0_seen_d = se0_s;   // an abort arrives with SE0 already seen
    end

    if (last_bit_s) begin
      case (state_q)
        ST_SYNC:  rcv_sync_d  = sr_next_s[63:56];
        ST_PID:   rcv_pid_d   = sr_next_s[63:56];
        ST_CRC5:  rcv_crc5_d  = sr_next_s[63:59];
        ST_CRC16: rcv_crc16_d = sr_next_s[63:48];
        ST_DATA:  rcv_data_d  = sr_next_s;
        default:  rcv_data_d  = rcv_data_q;
      endcase
    end else begin
      rcv_data_d = rcv_data_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt_q       <= 7'd0;
      sr_q        <= '0;
      se0_seen_q  <= 1'b0;
      rcv_sync_q  <= 8'h00;
      rcv_pid_q   <= 8'h00;
      rcv_crc5_q  <= 5'h00;
      rcv_crc16_q <= 16'h0000;
      rcv_data_q  <= 64'h0;
    end else begin
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      se0_seen_q  <= se0_seen_d;
      rcv_sync_q  <= rcv_sync_d;
      rcv_pid_q   <= rcv_pid_d;
      rcv_crc5_q  <= rcv_crc5_d;
      rcv_crc16_q <= rcv_crc16_d;
      rcv_data_q  <= rcv_data_d;
    end
  end

  assign rcv_sync  = rcv_sync_q;
  assign rcv_pid   = rcv_pid_q;
  assign rcv_crc5  = rcv_crc5_q;
  assign rcv_crc16 = rcv_crc16_q;
  assign rcv_data  = rcv_data_q;

endmodule

// File: tb/tb_usb_receiver.sv
// Directed bench for usb_receiver: NRZI-encodes hand-built packets onto
// D+/D- and checks the latched fields against hand-computed values.
module tb_usb_receiver;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        d_plus = 1'b1;
  logic        d_minus = 1'b0;
  logic [7:0]  rcv_sync, rcv_pid;
  logic [4:0]  rcv_crc5;
  logic [15:0] rcv_crc16;
  logic [63:0] rcv_data;

  int   total = 0;
  int   bad = 0;
  logic lvl = 1'b1;   // current NRZI line level, 1 = J

  usb_receiver #(.CLKS_PER_BIT(CPB), .SAMPLE_POINT(3)) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .d_plus   (d_plus),
    .d_minus  (d_minus),
    .rcv_sync (rcv_sync),
    .rcv_pid  (rcv_pid),
    .rcv_crc5 (rcv_crc5),
    .rcv_crc16(rcv_crc16),
    .rcv_data (rcv_data)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic dp, input logic dm, input int bits);
    d_plus  = dp;
    d_minus = dm;
    repeat (bits * CPB) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (!b) lvl = ~lvl;
    drive(lvl, ~lvl, 1);
  endtask

  task automatic send_field(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) send_bit(v[i]);
  endtask

  task automatic send_eop();
    drive(1'b0, 1'b0, 2);
    lvl = 1'b1;
    drive(1'b1, 1'b0, 1);
    drive(1'b1, 1'b0, 4);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (rcv_sync !== 8'h00)   begin bad++; $display("FAIL rst_sync got=%h exp=00", rcv_sync); end
    total++; if (rcv_pid !== 8'h00)    begin bad++; $display("FAIL rst_pid got=%h exp=00", rcv_pid); end
    total++; if (rcv_crc5 !== 5'h00)   begin bad++; $display("FAIL rst_crc5 got=%h exp=00", rcv_crc5); end
    total++; if (rcv_crc16 !== 16'h0)  begin bad++; $display("FAIL rst_crc16 got=%h exp=0", rcv_crc16); end
    total++; if (rcv_data !== 64'h0)   begin bad++; $display("FAIL rst_data got=%h exp=0", rcv_data); end
    n_rst = 1'b1;
    repeat (16) @(negedge clk);
    total++; if (rcv_sync !== 8'h00)   begin bad++; $display("FAIL idle_sync got=%h exp=00", rcv_sync); end
    total++; if (rcv_pid !== 8'h00)    begin bad++; $display("FAIL idle_pid got=%h exp=00", rcv_pid); end
    total++; if (rcv_data !== 64'h0)   begin bad++; $display("FAIL idle_data got=%h exp=0", rcv_data); end
  endtask

  task automatic test_token(input logic [4:0] crc, input string nm);
    send_field(64'h80, 8);
    send_field(64'h69, 8);
    send_field({59'h0, crc}, 5);
    send_eop();
    total++; if (rcv_sync !== 8'h80) begin bad++; $display("FAIL %s_sync got=%h exp=80", nm, rcv_sync); end
    total++; if (rcv_pid !== 8'h69)  begin bad++; $display("FAIL %s_pid got=%h exp=69", nm, rcv_pid); end
    total++; if (rcv_crc5 !== crc)   begin bad++; $display("FAIL %s_crc5 got=%b exp=%b", nm, rcv_crc5, crc); end
  endtask

  task automatic test_data();
    send_field(64'h80, 8);
    send_field(64'hC3, 8);
    send_field(64'hF0F0, 16);
    send_field(64'hFFFF0000FFFF0000, 64);
    send_eop();
    total++; if (rcv_pid !== 8'hC3)     begin bad++; $display("FAIL data_pid got=%h exp=c3", rcv_pid); end
    total++; if (rcv_crc16 !== 16'hF0F0) begin bad++; $display("FAIL data_crc16 got=%h exp=f0f0", rcv_crc16); end
    total++; if (rcv_data !== 64'hFFFF0000FFFF0000) begin bad++; $display("FAIL data_payload got=%h exp=ffff0000ffff0000", rcv_data); end
    total++; if (rcv_crc5 !== 5'b00110) begin bad++; $display("FAIL data_crc5_held got=%b exp=00110", rcv_crc5); end
  endtask

  task automatic test_handshake();
    send_field(64'h80, 8);
    send_field(64'hD2, 8);
    send_eop();
    total++; if (rcv_pid !== 8'hD2)      begin bad++; $display("FAIL ack_pid got=%h exp=d2", rcv_pid); end
    total++; if (rcv_crc5 !== 5'b00110)  begin bad++; $display("FAIL ack_crc5 got=%b exp=00110", rcv_crc5); end
    total++; if (rcv_crc16 !== 16'hF0F0) begin bad++; $display("FAIL ack_crc16 got=%h exp=f0f0", rcv_crc16); end
    total++; if (rcv_data !== 64'hFFFF0000FFFF0000) begin bad++; $display("FAIL ack_data got=%h", rcv_data); end
  endtask

  task automatic test_abort();
    send_field(64'h80, 8);
    send_field(64'hC3, 8);
    send_field(64'h1234, 16);
    send_field(64'h0123456789ABCDEF, 20);
    send_eop();
    total++; if (rcv_data !== 64'hFFFF0000FFFF0000) begin bad++; $display("FAIL abort_data got=%h exp=ffff0000ffff0000", rcv_data); end
    total++; if (rcv_crc16 !== 16'h1234) begin bad++; $display("FAIL abort_crc16 got=%h exp=1234", rcv_crc16); end
    test_token(5'b10101, "post_abort");
  endtask

  task automatic test_bad_pid();
    send_field(64'h80, 8);
    send_field(64'h00, 8);
    send_field(64'h5A, 8);
    send_eop();
    total++; if (rcv_pid !== 8'h00)     begin bad++; $display("FAIL badpid_pid got=%h exp=00", rcv_pid); end
    total++; if (rcv_crc5 !== 5'b10101) begin bad++; $display("FAIL badpid_crc5 got=%b exp=10101", rcv_crc5); end
    total++; if (rcv_crc16 !== 16'h1234) begin bad++; $display("FAIL badpid_crc16 got=%h exp=1234", rcv_crc16); end
    total++; if (rcv_data !== 64'hFFFF0000FFFF0000) begin bad++; $display("FAIL badpid_data got=%h", rcv_data); end
    send_field(64'h80, 8);
    send_field(64'hD2, 8);
    send_eop();
    total++; if (rcv_pid !== 8'hD2) begin bad++; $display("FAIL badpid_recover got=%h exp=d2", rcv_pid); end
  endtask

  task automatic test_reset_midpacket();
    send_field(64'h80, 8);
    send_field(64'h69, 4);
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (rcv_sync !== 8'h00) begin bad++; $display("FAIL midrst_sync got=%h exp=00", rcv_sync); end
    total++; if (rcv_data !== 64'h0) begin bad++; $display("FAIL midrst_data got=%h exp=0", rcv_data); end
    lvl = 1'b1;
    drive(1'b1, 1'b0, 2);
    n_rst = 1'b1;
    drive(1'b1, 1'b0, 2);
    test_token(5'b01001, "post_rst");
    total++; if (rcv_crc16 !== 16'h0) begin bad++; $display("FAIL post_rst_crc16 got=%h exp=0", rcv_crc16); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_token(5'b00110, "token");
    total++; if (rcv_crc16 !== 16'h0) begin bad++; $display("FAIL token_crc16 got=%h exp=0", rcv_crc16); end
    total++; if (rcv_data !== 64'h0)  begin bad++; $display("FAIL token_data got=%h exp=0", rcv_data); end
    test_data();
    test_handshake();
    test_abort();
    test_bad_pid();
    test_reset_midpacket();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_receiver.md
Name: usb_receiver

Overview:
- Simplified USB full-speed packet receiver; sits between the D+/D- line pins and the encryptor datapath.
- Oversamples the differential line, NRZI-decodes it and frames packets by SYNC/PID/EOP.
- Latches the fields of token, data and handshake packets onto parallel output registers that hold until overwritten.

Parameters:
- CLKS_PER_BIT, 8: system clocks per USB bit time.
- SAMPLE_POINT, 3: bit-timer count (0..CLKS_PER_BIT-1) at which the line is sampled.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- d_plus  in  1  USB D+ line (asynchronous).
- d_minus  in  1  USB D- line (asynchronous).
- rcv_sync  out  8  last decoded SYNC byte.
- rcv_pid  out  8  last decoded PID byte.
- rcv_crc5  out  5  last token CRC5.
- rcv_crc16  out  16  last data-packet CRC16.
- rcv_data  out  64  last data-packet payload (8 bytes).

Behaviour:
- Reset: all outputs 0; FSM in IDLE; NRZI previous level = J; bit timer 0.
- Inputs pass through a 2-flop synchronizer. Line states: J = (1,0), K = (0,1), SE0 = (0,0); (1,1) is treated as J.
- In IDLE, the first J->K transition starts a packet and zeroes the bit timer. The timer wraps every CLKS_PER_BIT clocks and restarts on every synchronized J/K transition to track drift.
- At count SAMPLE_POINT a sample strobe fires.
  - NRZI decode: same level as previous sample = 1; change = 0.
  - Bits are shifted LSB-first: the new bit enters the MSB and the register shifts right.
- FSM states: IDLE, SYNC, PID, CRC5, CRC16, DATA, EOP, ERR.
  - SYNC: 8 bits, then commit rcv_sync. Value must equal 8'h80; otherwise go to ERR.
  - PID: 8 bits, then commit rcv_pid unconditionally.
    - pid[7:4] != ~pid[3:0] -> ERR.
    - pid[1:0] = 01 (token) -> CRC5.
    - pid[1:0] = 11 (data) -> CRC16.
    - pid[1:0] = 10 (handshake) -> EOP.
    - pid[1:0] = 00 (special) -> ERR.
  - CRC5: 5 bits -> commit rcv_crc5 -> EOP. This simplified token has no address/endpoint field.
  - CRC16: 16 bits -> commit rcv_crc16 -> DATA.
  - DATA: 64 bits -> commit rcv_data -> EOP.
  - EOP: wait for SE0 sampled, then J sampled -> IDLE.
  - ERR: wait for SE0 then J -> IDLE. Nothing further is committed.
- SE0 sampled in any state other than IDLE/EOP aborts the packet: the partial field is discarded and the FSM goes to EOP awaiting J. SE0 in IDLE is ignored.
- Each output updates on the clock after its final bit's sample strobe and is otherwise held. Fields not present in a packet keep their previous values.
- CRC values are captured, not checked.
- n_rst asserted mid-packet returns the block to the reset state immediately.

Optional Feature:
- Macro USB_RX_BIT_UNSTUFF_EN.
  - Defined: after six consecutive decoded 1s, the next decoded bit is discarded (not shifted, not counted). If that bit is 1, go to ERR.
  - Undefined: no unstuffing; every sampled bit counts.
  - SYNC is excluded from the ones counter in both cases.

Decomposition:
- Package usb_rx_pkg: state enum, PID type codes (PID_IN=8'h69, PID_DATA0=8'hC3, PID_ACK=8'hD2), SYNC_PATTERN=8'h80, field lengths (8/8/5/16/64).
- Sub-module usb_rx_line_decoder: synchronizer, edge detect, bit timer, sample strobe, SE0 flag, NRZI decode (and unstuffing when enabled).
- The top holds the FSM, bit counter, shift register and output registers.

Test Plan:
- Reset: n_rst=0 -> all outputs 0; hold idle J for 16 clocks after release -> outputs unchanged.
- Token: SYNC KJKJKJKK, IN PID, CRC5 5'b00110, then SE0 2 bits and J -> rcv_sync=8'h80, rcv_pid=8'h69, rcv_crc5=5'b00110; crc16 and data stay 0.
- Data: DATA0 PID, CRC16 16'hF0F0, 64-bit payload 64'hFFFF0000FFFF0000, then EOP -> rcv_pid=8'hC3, rcv_crc16=16'hF0F0, rcv_data=64'hFFFF0000FFFF0000; rcv_crc5 retains the token value.
- Handshake: ACK PID then EOP -> rcv_pid=8'hD2; all other fields unchanged.
- Abort: SE0 injected after 20 data bits -> rcv_data unchanged; FSM back in IDLE; next token packet decoded correctly.
- Bad PID 8'h00 -> rcv_pid=8'h00; no CRC/data update; packet returns to IDLE after EOP.
